// File: rtl/dmux_pkg.sv
// Shared definitions for the dmux block: default sizes and the route decode
// that both the combinational path and the route counters agree on.
package dmux_pkg;

  // Default data width of in/a/b/a_q/b_q.
  localparam int DMUX_WIDTH_DEF = 1;

  // Default width of each saturating route counter.
  localparam int DMUX_CNT_W_DEF = 8;

  // Where the current input word is going this cycle.
  // ROUTE_NONE covers an all-zero word: it lands on an output, but carries
  // nothing worth counting.
  typedef enum logic [1:0] {
    ROUTE_NONE = 2'd0,
    ROUTE_A    = 2'd1,
    ROUTE_B    = 2'd2
  } route_e;

  // Classify the current transfer from the select line and a nonzero flag.
  function automatic route_e route_decode(input logic sel, input logic nonzero);
    route_e r;
    r = ROUTE_NONE;
    if (nonzero) begin
      r = sel ? ROUTE_B : ROUTE_A;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmux_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// It holds at all-ones instead of wrapping, so a debug read never shows a
// small value after a long busy period.
module dmux_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == {CNT_W{1'b1}});

  // Count enabled cycles, stop at the maximum value, clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_max) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dmux.sv
// 1-to-2 demultiplexer. The primary outputs a/b are purely combinational and
// ignore clk and rst_n. Registered copies (a_q/b_q) and per-output saturating
// route counters are provided for pipelined users and debug.
module dmux
  import dmux_pkg::*;
#(
  parameter int WIDTH = DMUX_WIDTH_DEF,
  parameter int CNT_W = DMUX_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_nonzero;
  route_e           w_route;
  logic             w_inc_a;
  logic             w_inc_b;
  logic [WIDTH-1:0] r_a_q;
  logic [WIDTH-1:0] r_b_q;

  // The unselected side is forced to zero, so a and b are never both nonzero.
  assign w_a = sel ? '0 : in;
  assign w_b = sel ? in : '0;

  assign a = w_a;
  assign b = w_b;

  // A cycle is counted only when a nonzero word is routed; the decode yields
  // a single route, so at most one counter advances per cycle.
  assign w_nonzero = |in;
  assign w_route   = route_decode(sel, w_nonzero);
  assign w_inc_a   = (w_route == ROUTE_A);
  assign w_inc_b   = (w_route == ROUTE_B);

  // One-cycle registered copies of the combinational outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_q <= '0;
      r_b_q <= '0;
    end else begin
      r_a_q <= w_a;
      r_b_q <= w_b;
    end
  end

  assign a_q = r_a_q;
  assign b_q = r_b_q;

  dmux_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_inc_a),
    .o_cnt (cnt_a)
  );

  dmux_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_inc_b),
    .o_cnt (cnt_b)
  );

endmodule

// File: tb/tb_dmux.sv
// Directed bench for dmux. Three instances: WIDTH=1 (truth table, counters),
// WIDTH=8 (wide routing and registered copies), WIDTH=1/CNT_W=2 (saturation).
module tb_dmux;

  logic clk;
  logic rst_n;

  // WIDTH=1, CNT_W=8
  logic       in1, sel1;
  logic       a1, b1, aq1, bq1;
  logic [7:0] ca1, cb1;

  // WIDTH=8, CNT_W=8
  logic [7:0] in8;
  logic       sel8;
  logic [7:0] a8, b8, aq8, bq8;
  logic [7:0] ca8, cb8;

  // WIDTH=1, CNT_W=2
  logic       ins, sels;
  logic       as_, bs, aqs, bqs;
  logic [1:0] cas, cbs;

  int checks;
  int errors;

  dmux #(.WIDTH(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel1),
    .a(a1), .b(b1), .a_q(aq1), .b_q(bq1), .cnt_a(ca1), .cnt_b(cb1)
  );

  dmux #(.WIDTH(8), .CNT_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8),
    .a(a8), .b(b8), .a_q(aq8), .b_q(bq8), .cnt_a(ca8), .cnt_b(cb8)
  );

  dmux #(.WIDTH(1), .CNT_W(2)) us (
    .clk(clk), .rst_n(rst_n), .in(ins), .sel(sels),
    .a(as_), .b(bs), .a_q(aqs), .b_q(bqs), .cnt_a(cas), .cnt_b(cbs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       w1;   // 1: row targets the WIDTH=1 instance, 0: WIDTH=8
    logic [7:0] in;
    logic       sel;
    logic [7:0] ea;
    logic [7:0] eb;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Watchdog: the run must always end by itself.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;

    tbl[0] = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 8'h00, 1'b1, 8'h00, 8'h00};
    tbl[2] = '{1'b1, 8'h01, 1'b0, 8'h01, 8'h00};
    tbl[3] = '{1'b1, 8'h01, 1'b1, 8'h00, 8'h01};
    tbl[4] = '{1'b0, 8'hA5, 1'b0, 8'hA5, 8'h00};
    tbl[5] = '{1'b0, 8'hA5, 1'b1, 8'h00, 8'hA5};
    tbl[6] = '{1'b0, 8'hFF, 1'b0, 8'hFF, 8'h00};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 8'h00, 8'h00};
    tbl[8] = '{1'b0, 8'h3C, 1'b1, 8'h00, 8'h3C};

    rst_n = 1'b0;
    in1 = 1'b0; sel1 = 1'b0;
    in8 = 8'h00; sel8 = 1'b0;
    ins = 1'b0; sels = 1'b0;
    #1;

    // Reset state of registered outputs and counters.
    chk("rst_aq1", {31'd0, aq1}, 32'd0);
    chk("rst_bq1", {31'd0, bq1}, 32'd0);
    chk("rst_ca1", {24'd0, ca1}, 32'd0);
    chk("rst_cb1", {24'd0, cb1}, 32'd0);
    chk("rst_aq8", {24'd0, aq8}, 32'd0);
    chk("rst_cas", {30'd0, cas}, 32'd0);

    // Combinational table, applied while held in reset (a/b ignore rst_n).
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].w1) begin
        in1  = tbl[i].in[0];
        sel1 = tbl[i].sel;
        #1;
        chk($sformatf("comb1_a[%0d]", i), {31'd0, a1}, {31'd0, tbl[i].ea[0]});
        chk($sformatf("comb1_b[%0d]", i), {31'd0, b1}, {31'd0, tbl[i].eb[0]});
      end else begin
        in8  = tbl[i].in;
        sel8 = tbl[i].sel;
        #1;
        chk($sformatf("comb8_a[%0d]", i), {24'd0, a8}, {24'd0, tbl[i].ea});
        chk($sformatf("comb8_b[%0d]", i), {24'd0, b8}, {24'd0, tbl[i].eb});
      end
    end

    // Release reset between edges with known inputs.
    @(negedge clk);
    in1 = 1'b0; sel1 = 1'b0;
    in8 = 8'hA5; sel8 = 1'b0;
    ins = 1'b0; sels = 1'b0;
    rst_n = 1'b1;

    // Registered copies, WIDTH=8.
    @(posedge clk); #1;
    chk("reg8_aq_sel0", {24'd0, aq8}, 32'h0000_00A5);
    chk("reg8_bq_sel0", {24'd0, bq8}, 32'd0);
    @(negedge clk);
    sel8 = 1'b1;
    @(posedge clk); #1;
    chk("reg8_aq_sel1", {24'd0, aq8}, 32'd0);
    chk("reg8_bq_sel1", {24'd0, bq8}, 32'h0000_00A5);

    // u1 has seen only in=0 so far.
    chk("cnt1_idle_a", {24'd0, ca1}, 32'd0);

    // Counter sequence on u1: 3x a, 2x b, 4x zero input.
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 3) begin
        in1 = 1'b1; sel1 = 1'b0;
      end else if (c < 5) begin
        in1 = 1'b1; sel1 = 1'b1;
      end else begin
        in1 = 1'b0; sel1 = c[0];
      end
      @(posedge clk); #1;
      if (c == 2) begin
        chk("cnt1_mid_a", {24'd0, ca1}, 32'd3);
        chk("cnt1_mid_b", {24'd0, cb1}, 32'd0);
      end
    end
    chk("cnt1_end_a", {24'd0, ca1}, 32'd3);
    chk("cnt1_end_b", {24'd0, cb1}, 32'd2);

    // Saturation on CNT_W=2: 5x a must stop at 3.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ins = 1'b1; sels = 1'b0;
      @(posedge clk); #1;
      if (c == 2) chk("sat_cnt_a_at3", {30'd0, cas}, 32'd3);
    end
    chk("sat_cnt_a_held", {30'd0, cas}, 32'd3);
    chk("sat_cnt_b",      {30'd0, cbs}, 32'd0);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ca1", {24'd0, ca1}, 32'd0);
    chk("arst_cb1", {24'd0, cb1}, 32'd0);
    chk("arst_cas", {30'd0, cas}, 32'd0);
    chk("arst_bq8", {24'd0, bq8}, 32'd0);
    chk("arst_aq8", {24'd0, aq8}, 32'd0);
    chk("arst_aqs", {31'd0, aqs}, 32'd0);
    sel8 = 1'b0;
    #1;
    chk("arst_a8_follow", {24'd0, a8}, 32'h0000_00A5);
    chk("arst_b8_follow", {24'd0, b8}, 32'd0);
    @(posedge clk); #1;
    chk("arst_hold_aq8", {24'd0, aq8}, 32'd0);

    // Resume after release: one b-routed cycle.
    @(negedge clk);
    rst_n = 1'b1;
    in1 = 1'b1; sel1 = 1'b1;
    ins = 1'b0;
    @(posedge clk); #1;
    chk("resume_cb1", {24'd0, cb1}, 32'd1);
    chk("resume_ca1", {24'd0, ca1}, 32'd0);
    chk("resume_bq1", {31'd0, bq1}, 32'd1);
    chk("resume_aq8", {24'd0, aq8}, 32'h0000_00A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
